// File: rtl/selector_draw_ctrl_pkg.sv
// Shared constants and state encoding for the selector ring sprite drawer.
// The screen geometry is also used by the framebuffer writer.
package selector_draw_ctrl_pkg;

    localparam int SPRITE_W = 59;
    localparam int SPRITE_H = 66;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int XW       = 9;
    localparam int YW       = 8;
    localparam int ROW_W    = 7;
    localparam int COL_W    = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        SCAN  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/selector_draw_ctrl.sv
// Walks the selector ring ROM row by row and turns each set, on-screen bit
// into a single (x,y) pixel-write request over a valid/ready handshake.
module selector_draw_ctrl
    import selector_draw_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [XW-1:0]       pos_x,
    input  logic [YW-1:0]       pos_y,
    output logic                busy,
    output logic                done,
    output logic [ROW_W-1:0]    rom_addr,
    input  logic [SPRITE_W-1:0] rom_data,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [XW-1:0]       pix_x,
    output logic [YW-1:0]       pix_y
);

    state_t               state;
    state_t               adv_state;
    logic [ROW_W-1:0]     row;
    logic [ROW_W-1:0]     adv_row;
    logic [COL_W-1:0]     col;
    logic [COL_W-1:0]     adv_col;
    logic [XW-1:0]        anc_x;
    logic [YW-1:0]        anc_y;
    logic [SPRITE_W-1:0]  row_buf;
    logic [XW:0]          px;
    logic [YW:0]          py;
    logic                 bit_set;
    logic                 last_col;

    assign rom_addr = row;

    // One extra bit on both sums so right/bottom clipping cannot wrap.
    assign px       = {1'b0, anc_x} + {{(XW + 1 - COL_W){1'b0}}, col};
    assign py       = {1'b0, anc_y} + {{(YW + 1 - ROW_W){1'b0}}, row};
    assign bit_set  = row_buf[COL_W'(SPRITE_W - 1) - col];
    assign last_col = (col == COL_W'(SPRITE_W - 1));

    // Column/row step shared by a skipped column in SCAN and a completed handshake in EMIT.
    always_comb begin
        adv_col   = col + COL_W'(1);
        adv_row   = row;
        adv_state = SCAN;
        if (last_col) begin
            adv_col = '0;
            if (row < ROW_W'(SPRITE_H - 1)) begin
                adv_row   = row + ROW_W'(1);
                adv_state = FETCH;
            end else begin
                adv_state = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            row       <= '0;
            col       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        anc_x <= pos_x;
                        anc_y <= pos_y;
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    row_buf <= rom_data;
                    // Rows only move downward, so the first off-screen row ends the draw.
                    if (py >= (YW + 1)'(SCREEN_H)) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        col   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (bit_set && (px < (XW + 1)'(SCREEN_W))) begin
                        pix_x     <= px[XW-1:0];
                        pix_y     <= py[YW-1:0];
                        pix_valid <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        col   <= adv_col;
                        row   <= adv_row;
                        state <= adv_state;
                        done  <= (adv_state == DONE);
                    end
                end
                EMIT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        col       <= adv_col;
                        row       <= adv_row;
                        state     <= adv_state;
                        done      <= (adv_state == DONE);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    row   <= '0;
                    col   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_selector_draw_ctrl.sv
// Scoreboard bench for selector_draw_ctrl with a behavioural ring ROM.
module tb_selector_draw_ctrl;
    import selector_draw_ctrl_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [XW-1:0]       pos_x;
    logic [YW-1:0]       pos_y;
    logic                busy;
    logic                done;
    logic [ROW_W-1:0]    rom_addr;
    logic [SPRITE_W-1:0] rom_data;
    logic                pix_valid;
    logic                pix_ready;
    logic [XW-1:0]       pix_x;
    logic [YW-1:0]       pix_y;

    logic [SPRITE_W-1:0] rom [SPRITE_H];

    selector_draw_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .pos_x(pos_x), .pos_y(pos_y),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y)
    );

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int hold = 0;
    bit rand_ready = 0;
    logic [16:0] exp_q[$];
    logic [16:0] got_q[$];
    logic [16:0] run1_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: scoreboard pops on every handshake, stall stability, done counting.
    bit          stall = 0;
    logic [XW-1:0] sx;
    logic [YW-1:0] sy;
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (pix_valid) begin
            if (stall) begin
                check("stall_x", pix_x, sx);
                check("stall_y", pix_y, sy);
            end
            if (pix_ready) begin
                got_q.push_back({pix_x, pix_y});
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL pix_extra: got (%0d,%0d) expected no pixel", pix_x, pix_y);
                end else begin
                    check("pix_seq", {pix_x, pix_y}, exp_q.pop_front());
                end
            end
            stall = !pix_ready;
            sx = pix_x;
            sy = pix_y;
        end else begin
            stall = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) begin
            if (hold > 0) begin
                pix_ready = 1'b0;
                hold--;
            end else begin
                pix_ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    function automatic void set_col(int r, int c);
        rom[r][SPRITE_W-1-c] = 1'b1;
    endfunction

    task automatic build_expected(input int x, input int y);
        for (int r = 0; r < SPRITE_H; r++) begin
            if (y + r >= SCREEN_H) break;
            for (int c = 0; c < SPRITE_W; c++)
                if (rom[r][SPRITE_W-1-c] && (x + c < SCREEN_W))
                    exp_q.push_back({9'(x + c), 8'(y + r)});
        end
    endtask

    task automatic draw(input int x, input int y, input bit rnd, output int addr_at_done);
        int n;
        int d0;
        bit seen;
        exp_q.delete();
        got_q.delete();
        build_expected(x, y);
        d0 = done_cnt;
        addr_at_done = -1;
        pos_x = 9'(x);
        pos_y = 8'(y);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        rand_ready = rnd;
        // Anchor changes while busy must not move the sprite.
        pos_x = 9'd7;
        pos_y = 8'd3;
        n = 0;
        seen = 0;
        while (n < 40000 && !seen) begin
            if (rnd && n == 40) start = 1'b1;
            if (rnd && n == 41) start = 1'b0;
            if (rnd && n == 100) hold = 20;
            tick();
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            $display("FAIL done_timeout: got no done expected done within 40000 cycles");
        end else begin
            addr_at_done = int'(rom_addr);
            check("busy_in_done", busy, 1);
            start = 1'b1;
            tick();
            start = 1'b0;
            rand_ready = 0;
            pix_ready = 1'b1;
            check("busy_after_done", busy, 0);
            tick();
            tick();
            check("start_in_done_ignored", busy, 0);
        end
        check("done_count", done_cnt - d0, 1);
        check("exp_drained", exp_q.size(), 0);
    endtask

    initial begin
        int addr;
        int cnt;
        int maxx;
        int mism;
        int n;
        logic [16:0] sel[$];

        for (int r = 0; r < SPRITE_H; r++) begin
            int left;
            rom[r] = '0;
            if (r == 0 || r == SPRITE_H - 1) begin
                for (int c = 26; c <= 32; c++) set_col(r, c);
            end else if (r == 17) begin
                set_col(r, 0); set_col(r, 1); set_col(r, 57); set_col(r, 58);
            end else begin
                left = (r < 33) ? ((25 - r < 0) ? 0 : 25 - r) : ((r - 40 < 0) ? 0 : r - 40);
                set_col(r, left);
                set_col(r, 58 - left);
            end
        end

        rst = 1'b1; start = 1'b0; pos_x = '0; pos_y = '0; pix_ready = 1'b1;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", pix_valid, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_rom_addr", rom_addr, 0);
        rst = 1'b0;
        tick();

        // Anchor (0,0): whole ring visible, 7+7+4+63*2 = 144 pixels.
        draw(0, 0, 0, addr);
        check("a00_count", got_q.size(), 144);
        if (got_q.size() > 6) begin
            check("a00_first", got_q[0], {9'd26, 8'd0});
            check("a00_seventh", got_q[6], {9'd32, 8'd0});
        end
        sel = got_q.find(p) with (p[7:0] == 8'd17);
        check("a00_row17_n", sel.size(), 4);
        if (sel.size() == 4) begin
            check("a00_row17_0", sel[0], {9'd0, 8'd17});
            check("a00_row17_1", sel[1], {9'd1, 8'd17});
            check("a00_row17_2", sel[2], {9'd57, 8'd17});
            check("a00_row17_3", sel[3], {9'd58, 8'd17});
        end
        check("a00_addr_done", addr, 65);
        run1_q = got_q;

        // Anchor (300,10): right-edge clipping.
        draw(300, 10, 0, addr);
        sel = got_q.find(p) with (p[7:0] == 8'd10);
        check("r_row0_n", sel.size(), 0);
        sel = got_q.find(p) with (p[7:0] == 8'd27);
        check("r_row17_n", sel.size(), 2);
        if (sel.size() == 2) begin
            check("r_row17_0", sel[0], {9'd300, 8'd27});
            check("r_row17_1", sel[1], {9'd301, 8'd27});
        end
        maxx = 0;
        foreach (got_q[i]) if (int'(got_q[i][16:8]) > maxx) maxx = int'(got_q[i][16:8]);
        check("r_max_x_lt_320", maxx < 320, 1);

        // Anchor (100,200): bottom clipping, rows 0..39 only = 7+4+38*2 = 87.
        draw(100, 200, 0, addr);
        check("b_count", got_q.size(), 87);
        if (got_q.size() > 0) check("b_last_y", got_q[got_q.size()-1][7:0], 239);
        check("b_addr_done", addr, 40);

        // Random ready with a 20-cycle stall, stray start mid-draw.
        draw(0, 0, 1, addr);
        check("rnd_count", got_q.size(), 144);
        mism = 0;
        foreach (run1_q[i]) if (i >= got_q.size() || got_q[i] !== run1_q[i]) mism++;
        check("rnd_same_as_ready1", mism, 0);

        // Reset while a pixel is stalled in EMIT.
        exp_q.delete();
        pix_ready = 1'b0;
        pos_x = '0;
        pos_y = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (n < 500 && !pix_valid) begin
            tick();
            n++;
        end
        if (!pix_valid) begin
            checks++;
            $display("FAIL emit_timeout: got no pix_valid expected pix_valid within 500 cycles");
        end
        check("emit_x", pix_x, 26);
        cnt = done_cnt;
        rst = 1'b1;
        tick();
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rom_addr", rom_addr, 0);
        check("mid_rst_done", done, 0);
        rst = 1'b0;
        tick();
        tick();
        check("mid_rst_no_done", done_cnt - cnt, 0);
        pix_ready = 1'b1;
        draw(0, 0, 0, addr);
        check("redraw_count", got_q.size(), 144);
        if (got_q.size() > 0) check("redraw_first", got_q[0], {9'd26, 8'd0});

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/selector_draw_ctrl.md
Name: selector_draw_ctrl

Overview:
Sequences the 66-row x 59-bit selector ring bitmap ROM and converts its set bits into individual pixel-write requests for the framebuffer writer.
- Takes an on-screen anchor (top-left corner) and a start pulse.
- Walks ROM rows in order and scans columns within each row.
- Clips pixels against screen bounds.
- Emits one (x,y) per set, in-bounds bit over a valid/ready handshake.
- Sits between the game-state logic that places the selector and the shared framebuffer write port.

Parameters:
SPRITE_W, 59, bits per ROM row (columns)
SPRITE_H, 66, ROM rows
SCREEN_W, 320, screen width in pixels; x >= SCREEN_W is clipped
SCREEN_H, 240, screen height in pixels; y >= SCREEN_H is clipped
XW, 9, pixel x width (clog2 SCREEN_W)
YW, 8, pixel y width (clog2 SCREEN_H)

Ports:
clk  in  1  system clock
rst  in  1  reset
start  in  1  draw request; sampled only in IDLE
pos_x  in  XW  sprite anchor x; latched on accepted start
pos_y  in  YW  sprite anchor y; latched on accepted start
busy  out  1  high from the cycle after accepted start until DONE exits
done  out  1  one-cycle pulse in the DONE state
rom_addr  out  7  row address to the selector ROM
rom_data  in  SPRITE_W  ROM row; column c = bit (SPRITE_W-1-c), so MSB is leftmost
pix_valid  out  1  pixel request valid
pix_ready  in  1  downstream accepts the pixel
pix_x  out  XW  pixel x = pos_x + col
pix_y  out  YW  pixel y = pos_y + row

Behaviour:
- Single clock domain clk. Reset rst is synchronous and active-high.
- Reset: state IDLE; busy=0, done=0, pix_valid=0, pix_x=0, pix_y=0, rom_addr=0; row/col counters = 0.
- All outputs are registered except rom_addr, which is driven directly from the row counter.
- States: IDLE, FETCH, SCAN, EMIT, DONE.
- IDLE: rom_addr=0.
  - start=1 latches pos_x/pos_y, sets row=0, moves to FETCH.
  - start is ignored in every other state; there is no queueing.
- FETCH (1 cycle): rom_addr=row.
  - Captures rom_data into row_buf at the end of the cycle. This allows block-ROM inference with a 1-cycle read.
  - If pos_y+row >= SCREEN_H (computed YW+1 wide), goes to DONE instead, because no later row can be on screen.
  - Otherwise sets col=0 and goes to SCAN.
- SCAN: examines one column per cycle.
  - bit = row_buf[SPRITE_W-1-col]. px = pos_x+col, computed XW+1 wide.
  - If bit=1 and px < SCREEN_W: register pix_x=px, pix_y=pos_y+row, pix_valid=1, go to EMIT.
  - Else, if col < SPRITE_W-1: col++.
  - Else, at the last column: if row < SPRITE_H-1, row++ and go to FETCH; otherwise go to DONE.
- EMIT: pix_valid held at 1 and pix_x/pix_y held stable until pix_ready=1.
  - On the handshake (valid & ready): pix_valid=0 next cycle, and col/row advance exactly as in SCAN's "else" branch.
  - Next state: SCAN, FETCH, or DONE accordingly.
- Every set, in-bounds bit yields exactly one handshake. There are no duplicates and no drops.
- Pixels are emitted in row-major order, increasing col within a row.
- DONE (1 cycle): done=1, busy=0 next cycle, then return to IDLE. A start in the DONE cycle is ignored.
- Latency: start sampled high in cycle N gives FETCH in N+1 and SCAN col 0 in N+2. A set bit at col 0 gives pix_valid in N+3.
- Throughput: one column per cycle in SCAN. A set pixel costs at least 2 cycles (SCAN + EMIT).
- With pix_ready stuck high and every pixel clipped, a full draw takes 66 x (1+59) + 2 cycles.
- Clipped pixels are skipped silently. The row loop continues after clipping on the right edge.
- rst asserted mid-draw returns to IDLE on the next edge.
  - pix_valid drops even if the handshake is not complete; this is the only permitted handshake break.
  - done is not pulsed.
- Anchor changes on pos_x/pos_y while busy have no effect.

Decomposition:
- Shared package:
  - SPRITE_W/SPRITE_H.
  - State encoding constants (IDLE=0, FETCH=1, SCAN=2, EMIT=3, DONE=4).
  - Screen-size constants shared with the framebuffer writer.
- The ROM is instantiated by the parent, not inside this block. No sub-module is needed; it is one FSM plus counters.

Test Plan:
- pos=(0,0), pix_ready=1, start: first handshake at (26,0), then (27,0)..(32,0); row 17 emits exactly (0,17),(1,17),(57,17),(58,17). Total handshakes = popcount of all 66 ROM rows (golden model). done pulses once.
- pos=(300,10): row 0 emits nothing (cols 26..32 clipped); row 17 emits only (300,27),(301,27); no pix_x >= 320 ever appears.
- pos=(100,200): last emitted y = 239; DONE is reached when row reaches 40 (200+40 = 240); done asserts and busy drops.
- pix_ready driven randomly (including held low for 20 cycles): pix_x/pix_y stay stable while valid and not ready; the emitted sequence is identical to the ready=1 run.
- start pulsed again mid-draw and in the DONE cycle: ignored; exactly one done per accepted start.
- rst asserted during EMIT with ready=0: next cycle pix_valid=0, busy=0, rom_addr=0, no done; a new start redraws from row 0.
